// File: rtl/sample_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_acc_pkg
// Description : Shared definitions for the sample_acc_relu block. This package
//               holds the FSM state encoding and the default parameter set
//               (product width, output width, term limit and accumulator
//               width).
// Revision    : 1.0 - initial release
// ============================================================================
package sample_acc_pkg;

    // Default parameter bundle. The accumulator must hold
    // DIN_WIDTH + clog2(MAX_TERMS) + 1 bits: 11 + 8 + 1 = 20 for the defaults.
    localparam int C_DIN_WIDTH  = 11;
    localparam int C_DOUT_WIDTH = 16;
    localparam int C_MAX_TERMS  = 256;
    localparam int C_ACC_WIDTH  = 20;

    // ST_ACC : collecting product beats
    // ST_OUT : holding a finished result until downstream takes it
    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

endpackage : sample_acc_pkg
`default_nettype wire

// File: rtl/sample_acc_relu_sat.sv
`default_nettype none
// ============================================================================
// Module      : sample_acc_relu_sat
// Description : Combinational ReLU with upper clamp. This block takes a signed
//               ACC_WIDTH value and produces a non-negative DOUT_WIDTH result
//               in the range 0 .. 2^(DOUT_WIDTH-1)-1.
//               Ports: i_acc  - signed accumulator value
//                      o_data - ReLU / clamped result
//                      o_sat  - result was clipped to the positive maximum
// Revision    : 1.0 - initial release
// ============================================================================
module sample_acc_relu_sat #(
    parameter int ACC_WIDTH  = 20,
    parameter int DOUT_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0]  i_acc,
    output logic        [DOUT_WIDTH-1:0] o_data,
    output logic                         o_sat
);

    logic w_neg;
    logic w_hi;

    assign w_neg = i_acc[ACC_WIDTH-1];

    // A positive value exceeds the output range when any bit between the sign
    // bit and the output MSB position is set. When the two widths are equal,
    // every non-negative value already fits.
    generate
        if (ACC_WIDTH > DOUT_WIDTH) begin : g_wide
            assign w_hi = |i_acc[ACC_WIDTH-2:DOUT_WIDTH-1];
        end else begin : g_equal
            assign w_hi = 1'b0;
        end
    endgenerate

    always_comb begin
        o_data = '0;
        o_sat  = 1'b0;
        if (w_neg) begin
            o_data = '0;
        end else if (w_hi) begin
            o_data = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            o_sat  = 1'b1;
        end else begin
            o_data = {1'b0, i_acc[DOUT_WIDTH-2:0]};
        end
    end

endmodule : sample_acc_relu_sat
`default_nettype wire

// File: rtl/sample_acc_relu.sv
`default_nettype none
// ============================================================================
// Module      : sample_acc_relu
// Description : This block accumulates signed product beats into a dot product
//               and adds a bias on the first beat. It applies ReLU and clamps
//               the result to the output width. One result is presented per
//               dot product through a valid/ready handshake.
//               Ports: clk, reset (sync, active high), ce (clock enable)
//                      in_valid/in_ready/in_data/in_last/bias - beat input
//                      out_valid/out_ready/out_data/out_sat/out_ovf - result
// Revision    : 1.0 - initial release
// ============================================================================
module sample_acc_relu
    import sample_acc_pkg::*;
#(
    parameter int DIN_WIDTH  = C_DIN_WIDTH,
    parameter int DOUT_WIDTH = C_DOUT_WIDTH,
    parameter int MAX_TERMS  = C_MAX_TERMS,
    parameter int ACC_WIDTH  = C_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN_WIDTH-1:0]  in_data,
    input  logic                         in_last,
    input  logic signed [DOUT_WIDTH-1:0] bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [DOUT_WIDTH-1:0] out_data,
    output logic                         out_sat,
    output logic                         out_ovf
);

    localparam int CNT_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

    state_t                        r_state;
    state_t                        w_state_next;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic        [CNT_W-1:0]       r_count;
    logic                          r_first;
    logic        [DOUT_WIDTH-1:0]  r_out_data;
    logic                          r_out_sat;
    logic                          r_out_ovf;

    logic                          w_accept;
    logic                          w_take;
    logic                          w_cnt_end;
    logic                          w_term;
    logic                          w_ovf;
    logic signed [ACC_WIDTH-1:0]   w_base;
    logic signed [ACC_WIDTH-1:0]   w_acc_next;
    logic        [DOUT_WIDTH-1:0]  w_sat_data;
    logic                          w_sat_flag;

    // ------------------------------------------------------------------
    // Datapath: sign-extend, add, clamp
    // ------------------------------------------------------------------
    // The first beat starts from the bias instead of the running sum, so no
    // separate clear cycle is needed between dot products.
    assign w_base     = r_first ? ACC_WIDTH'(bias) : r_acc;
    assign w_acc_next = w_base + ACC_WIDTH'(in_data);

    // r_count holds the number of beats accepted so far. The beat that sees
    // MAX_TERMS-1 is therefore the MAX_TERMS-th beat and closes the product.
    assign w_cnt_end = (r_count == CNT_W'(MAX_TERMS - 1));
    assign w_term    = in_last || w_cnt_end;
    assign w_ovf     = w_cnt_end && !in_last;

    sample_acc_relu_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_sat (
        .i_acc  (w_acc_next),
        .o_data (w_sat_data),
        .o_sat  (w_sat_flag)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ACC;
        end else if (ce) begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        w_take       = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = ce;
                w_accept = ce && in_valid;
                if (w_accept && w_term) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                // in_ready stays low here, so a beat waiting during the
                // handshake cycle is taken only on the following cycle.
                w_take = ce && out_ready;
                if (w_take) begin
                    w_state_next = ST_ACC;
                end
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

    assign out_valid = (r_state == ST_OUT);

    // ------------------------------------------------------------------
    // Accumulator, beat counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_first    <= 1'b1;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
            r_out_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CNT_W'(1);
            r_first <= 1'b0;
            if (w_term) begin
                r_out_data <= w_sat_data;
                r_out_sat  <= w_sat_flag;
                r_out_ovf  <= w_ovf;
            end
        end else if (w_take) begin
            r_acc   <= '0;
            r_count <= '0;
            r_first <= 1'b1;
        end
    end

    assign out_data = r_out_data;
    assign out_sat  = r_out_sat;
    assign out_ovf  = r_out_ovf;

endmodule : sample_acc_relu
`default_nettype wire

// File: tb/tb_sample_acc_relu.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_acc_relu
// Description : Self-checking bench for sample_acc_relu. The bench applies
//               table-driven dot-product vectors and then runs directed
//               sequences that exercise the term limit, back-pressure,
//               clock enable and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_acc_relu;

    logic               clk;
    logic               reset;
    logic               ce;
    logic               in_valid;
    logic               in_ready;
    logic signed [10:0] in_data;
    logic               in_last;
    logic signed [15:0] bias;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_data;
    logic               out_sat;
    logic               out_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    sample_acc_relu #(
        .DIN_WIDTH  (11),
        .DOUT_WIDTH (16),
        .MAX_TERMS  (256),
        .ACC_WIDTH  (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [15:0] bias;
        int                 n;
        logic [7:0][10:0]   beats;
        logic [15:0]        exp_data;
        logic               exp_sat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one beat from a negedge, wait (bounded) for in_ready, let it be
    // captured on the next posedge and drop in_valid 1 ns later.
    task automatic send_beat(input logic [10:0] d, input logic last, input logic [15:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        bias     = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("beat_accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_result(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (!(out_valid && ce) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) begin
            chk({name, "_take_timeout"}, 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_valid_after_take"}, 32'(out_valid), 32'd0);
        chk({name, "_ready_after_take"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        for (int i = 0; i < v.n; i++) begin
            send_beat(v.beats[i], (i == v.n - 1), v.bias);
            if (i < v.n - 1) begin
                chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
            end
        end
        // Result must be visible exactly one edge after the last beat.
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_data"},  32'(out_data),  32'(v.exp_data));
        chk({nm, "_sat"},   32'(out_sat),   32'(v.exp_sat));
        chk({nm, "_ovf"},   32'(out_ovf),   32'd0);
        take_result(nm);
    endtask

    logic [15:0] held_data;

    initial begin
        // ---------------- vector table ----------------
        for (int k = 0; k < 6; k++) vecs[k] = '0;
        // 5 + 10 - 3 + 7 = 19
        vecs[0].bias = 16'sd5;     vecs[0].n = 3;
        vecs[0].beats[0] = 11'd10; vecs[0].beats[1] = -11'sd3; vecs[0].beats[2] = 11'd7;
        vecs[0].exp_data = 16'd19; vecs[0].exp_sat = 1'b0;
        // -100 + 20 + 30 = -50 -> 0
        vecs[1].bias = -16'sd100;  vecs[1].n = 2;
        vecs[1].beats[0] = 11'd20; vecs[1].beats[1] = 11'd30;
        vecs[1].exp_data = 16'd0;  vecs[1].exp_sat = 1'b0;
        // 32000 + 8*1023 = 40184 -> clamp 32767
        vecs[2].bias = 16'sd32000; vecs[2].n = 8;
        for (int k = 0; k < 8; k++) vecs[2].beats[k] = 11'd1023;
        vecs[2].exp_data = 16'd32767; vecs[2].exp_sat = 1'b1;
        // single beat: 7 + (-3) = 4
        vecs[3].bias = 16'sd7;     vecs[3].n = 1;
        vecs[3].beats[0] = -11'sd3;
        vecs[3].exp_data = 16'd4;  vecs[3].exp_sat = 1'b0;
        // single beat: 32767 + 1 = 32768 -> clamp
        vecs[4].bias = 16'sd32767; vecs[4].n = 1;
        vecs[4].beats[0] = 11'd1;
        vecs[4].exp_data = 16'd32767; vecs[4].exp_sat = 1'b1;
        // exact fit: 32000 + 767 = 32767, not clipped
        vecs[5].bias = 16'sd32000; vecs[5].n = 1;
        vecs[5].beats[0] = 11'd767;
        vecs[5].exp_data = 16'd32767; vecs[5].exp_sat = 1'b0;

        // ---------------- reset ----------------
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        bias = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_sat",   32'(out_sat),   32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);

        // ---------------- table ----------------
        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // ---------------- term limit: 256 beats of 1, no in_last ----------------
        for (int i = 0; i < 256; i++) begin
            send_beat(11'd1, 1'b0, 16'd0);
            if (i == 254) chk("lim_early_valid", 32'(out_valid), 32'd0);
        end
        chk("lim_valid", 32'(out_valid), 32'd1);
        chk("lim_data",  32'(out_data),  32'd256);
        chk("lim_ovf",   32'(out_ovf),   32'd1);
        chk("lim_sat",   32'(out_sat),   32'd0);
        // 257th beat waits while the result is pending
        @(negedge clk);
        in_valid = 1'b1; in_data = 11'd1; in_last = 1'b1; bias = 16'd0;
        for (int i = 0; i < 3; i++) begin
            chk("lim_257_blocked", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("lim_257_blocked_take", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("lim_valid_after_take", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("lim_257_valid", 32'(out_valid), 32'd1);
        chk("lim_257_data",  32'(out_data),  32'd1);
        chk("lim_257_ovf",   32'(out_ovf),   32'd0);
        take_result("lim_257");

        // ---------------- back-pressure and clock enable ----------------
        send_beat(11'd10, 1'b1, 16'sd5);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data",  32'(out_data),  32'd15);
        held_data = out_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data",  32'(out_data),  32'(held_data));
        end
        @(negedge clk);
        ce = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("ce0_valid",    32'(out_valid), 32'd1);
            chk("ce0_data",     32'(out_data),  32'd15);
            chk("ce0_in_ready", 32'(in_ready),  32'd0);
        end
        @(negedge clk);
        ce = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ce1_handshake", 32'(out_valid), 32'd0);

        // ---------------- reset mid dot product ----------------
        send_beat(11'd100, 1'b0, 16'sd50);
        send_beat(11'd200, 1'b0, 16'sd50);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rmid_valid",    32'(out_valid), 32'd0);
        chk("rmid_in_ready", 32'(in_ready),  32'd1);
        send_beat(11'd2, 1'b1, 16'sd1);
        chk("rmid_new_valid", 32'(out_valid), 32'd1);
        chk("rmid_new_data",  32'(out_data),  32'd3);
        take_result("rmid");

        // ---------------- reset with result pending ----------------
        send_beat(11'd5, 1'b1, 16'sd0);
        chk("rpend_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rpend_cleared", 32'(out_valid), 32'd0);
        chk("rpend_data",    32'(out_data),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sample_acc_relu
`default_nettype wire
